// File: rtl/score_pkg.sv
// Shared constants, state type and helpers for the score bank / display slice.
package score_pkg;

    localparam int SCORE_WIDTH = 13;
    localparam int NDIGITS     = 4;

    localparam logic [1:0] REG_ROUND  = 2'd0;
    localparam logic [1:0] REG_SCORE1 = 2'd1;
    localparam logic [1:0] REG_SCORE2 = 2'd2;
    localparam logic [1:0] REG_SCORE3 = 2'd3;

    // Active-low segment codes, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic [1:0] {
        BCD_IDLE,
        BCD_SHIFT,
        BCD_DONE
    } bcd_state_t;

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = SEG_0;
            4'd1:    s = SEG_1;
            4'd2:    s = SEG_2;
            4'd3:    s = SEG_3;
            4'd4:    s = SEG_4;
            4'd5:    s = SEG_5;
            4'd6:    s = SEG_6;
            4'd7:    s = SEG_7;
            4'd8:    s = SEG_8;
            4'd9:    s = SEG_9;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    // Double-dabble correction: add 3 to every BCD digit that is 5 or more
    function automatic logic [4*NDIGITS-1:0] bcd_add3(input logic [4*NDIGITS-1:0] b);
        logic [4*NDIGITS-1:0] r;
        r = b;
        for (int i = 0; i < NDIGITS; i++) begin
            if (r[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = r[4*i +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter: one operand load, WIDTH shift/add-3 steps, one done cycle.
//
// state     | meaning
// BCD_IDLE  | waiting for start, operand captured when start is high
// BCD_SHIFT | one add-3 + shift per cycle, WIDTH cycles in total
// BCD_DONE  | bcd holds the final result, done pulses for one cycle
module bin2bcd_seq
    import score_pkg::*;
#(
    parameter int WIDTH = SCORE_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] operand,
    output logic             busy,
    output logic             done,
    output logic [15:0]      bcd
);

    localparam int CW = $clog2(WIDTH + 1);

    bcd_state_t       state, state_next;
    logic [WIDTH-1:0] bin, bin_next;
    logic [15:0]      bcd_r, bcd_next;
    logic [CW-1:0]    cnt, cnt_next;
    logic [15+WIDTH:0] shifted;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= BCD_IDLE;
            bin   <= '0;
            bcd_r <= '0;
            cnt   <= '0;
        end else begin
            state <= state_next;
            bin   <= bin_next;
            bcd_r <= bcd_next;
            cnt   <= cnt_next;
        end
    end

    // Next-state, shift step and status outputs
    always_comb begin
        state_next = state;
        bin_next   = bin;
        bcd_next   = bcd_r;
        cnt_next   = cnt;
        busy       = 1'b0;
        done       = 1'b0;
        shifted    = {bcd_add3(bcd_r), bin} << 1;
        case (state)
            BCD_IDLE: begin
                if (start) begin
                    bin_next   = operand;
                    bcd_next   = '0;
                    cnt_next   = CW'(WIDTH - 1);
                    state_next = BCD_SHIFT;
                end
            end
            BCD_SHIFT: begin
                busy     = 1'b1;
                bcd_next = shifted[15+WIDTH:WIDTH];
                bin_next = shifted[WIDTH-1:0];
                if (cnt == '0) begin
                    state_next = BCD_DONE;
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
            BCD_DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                state_next = BCD_IDLE;
            end
            default: state_next = BCD_IDLE;
        endcase
    end

    assign bcd = bcd_r;

endmodule

// File: rtl/score_bank_display.sv
// Score register bank with a BCD-converted, multiplexed 4-digit 7-segment display.
module score_bank_display
    import score_pkg::*;
#(
    parameter int WIDTH    = SCORE_WIDTH,
    parameter int SCAN_DIV = 1024
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             registerLoad,
    input  logic [1:0]       loadAddr,
    input  logic [WIDTH-1:0] registerLoadData,
    input  logic [1:0]       qAddr,
    output logic [WIDTH-1:0] registerDataP,
    output logic [WIDTH-1:0] registerDataQ,
    input  logic [1:0]       DisplayScoreControl,
    output logic [WIDTH-1:0] DisplayScore,
    output logic             convBusy,
    output logic [3:0]       anode,
    output logic [6:0]       segments
);

    localparam int SW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

    logic [WIDTH-1:0] bank [4];
    logic [WIDTH-1:0] sel_val;
    logic             trigger;
    logic             eng_done;
    logic [15:0]      eng_bcd;
    logic [1:0]       pend_idx, shown_idx;
    logic [WIDTH-1:0] pend_val;
    logic             shown_valid;
    logic [15:0]      digits, digits_next;
    logic [SW-1:0]    scan_cnt;
    logic [1:0]       digit_sel, digit_sel_next;
    logic [3:0]       nibble;
    logic             blank;

    // Register bank writes; reads below see only stored state
    always_ff @(posedge Clock) begin
        if (Reset) begin
            for (int i = 0; i < 4; i++) bank[i] <= '0;
        end else if (registerLoad) begin
            bank[loadAddr] <= registerLoadData;
        end
    end

    assign registerDataP = bank[REG_ROUND];
    assign registerDataQ = bank[qAddr];
    assign sel_val       = bank[DisplayScoreControl];

    // shown_valid low after reset forces one conversion of the selected register
    assign trigger = !convBusy &&
                     (!shown_valid || DisplayScoreControl != shown_idx || sel_val != DisplayScore);

    bin2bcd_seq #(.WIDTH(WIDTH)) u_bcd (
        .clk     (Clock),
        .rst     (Reset),
        .start   (trigger),
        .operand (sel_val),
        .busy    (convBusy),
        .done    (eng_done),
        .bcd     (eng_bcd)
    );

    // Remember what is being converted; publish digits and value together on completion
    always_ff @(posedge Clock) begin
        if (Reset) begin
            pend_idx     <= '0;
            pend_val     <= '0;
            shown_idx    <= '0;
            shown_valid  <= 1'b0;
            DisplayScore <= '0;
            digits       <= '0;
        end else begin
            if (trigger) begin
                pend_idx <= DisplayScoreControl;
                pend_val <= sel_val;
            end
            if (eng_done) begin
                shown_idx    <= pend_idx;
                shown_valid  <= 1'b1;
                DisplayScore <= pend_val;
                digits       <= eng_bcd;
            end
        end
    end

    // Next digit selection and its segment pattern, with leading-zero blanking
    always_comb begin
        digit_sel_next = digit_sel;
        if (scan_cnt == SW'(SCAN_DIV - 1)) digit_sel_next = digit_sel + 1'b1;
        digits_next = eng_done ? eng_bcd : digits;
        nibble      = digits_next[{digit_sel_next, 2'b00} +: 4];
        blank       = 1'b0;
        case (digit_sel_next)
            2'd1:    blank = (digits_next[15:4]  == '0);
            2'd2:    blank = (digits_next[15:8]  == '0);
            2'd3:    blank = (digits_next[15:12] == '0);
            default: blank = 1'b0;
        endcase
    end

    // Scan counter and registered anode/segment drive, updated on the same edge
    always_ff @(posedge Clock) begin
        if (Reset) begin
            scan_cnt  <= '0;
            digit_sel <= '0;
            anode     <= 4'b1110;
            segments  <= SEG_0;
        end else begin
            scan_cnt  <= (scan_cnt == SW'(SCAN_DIV - 1)) ? '0 : scan_cnt + 1'b1;
            digit_sel <= digit_sel_next;
            anode     <= ~(4'b0001 << digit_sel_next);
            segments  <= blank ? SEG_BLANK : seg_decode(nibble);
        end
    end

endmodule

// File: tb/tb_score_bank_display.sv
// Randomized bench for score_bank_display with a behavioural reference model and scoreboard.
module tb_score_bank_display;

    localparam int WIDTH    = 13;
    localparam int SCAN_DIV = 4;

    logic             clk = 1'b0;
    logic             Reset;
    logic             registerLoad;
    logic [1:0]       loadAddr;
    logic [WIDTH-1:0] registerLoadData;
    logic [1:0]       qAddr;
    logic [WIDTH-1:0] registerDataP, registerDataQ;
    logic [1:0]       DisplayScoreControl;
    logic [WIDTH-1:0] DisplayScore;
    logic             convBusy;
    logic [3:0]       anode;
    logic [6:0]       segments;

    always #5 clk = ~clk;

    score_bank_display #(.WIDTH(WIDTH), .SCAN_DIV(SCAN_DIV)) dut (
        .Clock               (clk),
        .Reset               (Reset),
        .registerLoad        (registerLoad),
        .loadAddr            (loadAddr),
        .registerLoadData    (registerLoadData),
        .qAddr               (qAddr),
        .registerDataP       (registerDataP),
        .registerDataQ       (registerDataQ),
        .DisplayScoreControl (DisplayScoreControl),
        .DisplayScore        (DisplayScore),
        .convBusy            (convBusy),
        .anode               (anode),
        .segments            (segments)
    );

    int vectors    = 0;
    int miscompares = 0;
    int pops       = 0;

    // reference model state
    int m_reg [4];
    int m_busy, m_idx, m_val, m_disp, m_cyc;
    bit m_valid;
    bit armed = 1'b0;
    int exp_q [$];
    bit prev_busy = 1'b0;

    task automatic chk(input string name, input int act, input int req);
        vectors++;
        if (act != req) begin
            miscompares++;
            $display("FAIL %s at %0t: actual=%0d required=%0d", name, $time, act, req);
        end
    endtask

    function automatic int pow10(input int k);
        int p = 1;
        for (int i = 0; i < k; i++) p = p * 10;
        return p;
    endfunction

    function automatic int exp_seg(input int v, input int k);
        int d;
        if (k > 0 && v < pow10(k)) return 'h7F;
        d = (v / pow10(k)) % 10;
        case (d)
            0: return 'h40;  1: return 'h79;  2: return 'h24;  3: return 'h30;
            4: return 'h19;  5: return 'h12;  6: return 'h02;  7: return 'h78;
            8: return 'h00;  default: return 'h10;
        endcase
    endfunction

    // Model: registers, conversion scheduling (busy WIDTH+1 cycles after trigger), scan position
    always @(posedge clk) begin
        if (Reset) begin
            for (int i = 0; i < 4; i++) m_reg[i] = 0;
            m_busy  = 0; m_idx = 0; m_val = 0; m_disp = 0; m_cyc = 0;
            m_valid = 1'b0;
            exp_q.delete();
            armed   = 1'b1;
        end else if (armed) begin
            if (m_busy != 0) begin
                m_busy--;
                if (m_busy == 0) m_disp = m_val;
            end else if (!m_valid || int'(DisplayScoreControl) != m_idx ||
                         m_reg[DisplayScoreControl] != m_val) begin
                m_idx   = int'(DisplayScoreControl);
                m_val   = m_reg[DisplayScoreControl];
                m_valid = 1'b1;
                m_busy  = WIDTH + 1;
                exp_q.push_back(m_val);
            end
            if (registerLoad) m_reg[loadAddr] = int'(registerLoadData);
            m_cyc++;
        end
    end

    // Monitor: scoreboard pop on each completed conversion plus per-cycle output checks
    always @(negedge clk) begin
        if (armed) begin
            if (Reset) begin
                prev_busy = 1'b0;
            end else begin
                if (prev_busy && !convBusy) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_conversion", 1, 0);
                    end else begin
                        chk("display_score", int'(DisplayScore), exp_q.pop_front());
                        pops++;
                    end
                end
                prev_busy = convBusy;
            end
            chk("conv_busy", int'(convBusy), int'(m_busy != 0));
            chk("data_p", int'(registerDataP), m_reg[0]);
            chk("data_q", int'(registerDataQ), m_reg[qAddr]);
            chk("shown_value", int'(DisplayScore), m_disp);
            chk("anode", int'(anode), int'(~(4'b0001 << ((m_cyc / SCAN_DIV) % 4)) & 4'hF));
            chk("segments", int'(segments), exp_seg(m_disp, (m_cyc / SCAN_DIV) % 4));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic write(input int addr, input int data);
        registerLoad     = 1'b1;
        loadAddr         = 2'(addr);
        registerLoadData = WIDTH'(data);
        tick(1);
        registerLoad     = 1'b0;
    endtask

    initial begin
        Reset = 1'b1; registerLoad = 1'b0; loadAddr = '0; registerLoadData = '0;
        qAddr = '0; DisplayScoreControl = '0;
        tick(2);
        Reset = 1'b0;
        tick(WIDTH + 3 + 16);

        write(0, 3);
        qAddr = 2'd2;
        write(2, 1234);
        tick(2);

        DisplayScoreControl = 2'd2;
        tick(3);
        write(2, 8191);
        tick(2 * (WIDTH + 2) + 20);

        write(2, 9);
        tick(1);
        write(2, 8191);
        tick(4);
        write(2, 42);
        tick(2 * (WIDTH + 2) + 20);

        write(1, 777);
        DisplayScoreControl = 2'd1;
        tick(5);
        Reset = 1'b1;
        tick(1);
        Reset = 1'b0;
        tick(WIDTH + 8);

        for (int i = 0; i < 400; i++) begin
            registerLoad        = ($urandom_range(0, 3) == 0);
            loadAddr            = 2'($urandom_range(0, 3));
            registerLoadData    = ($urandom_range(0, 1) == 0) ? WIDTH'($urandom_range(0, 120))
                                                               : WIDTH'($urandom_range(0, 8191));
            qAddr               = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 15) == 0) DisplayScoreControl = 2'($urandom_range(0, 3));
            Reset               = ($urandom_range(0, 149) == 0);
            tick(1);
            Reset = 1'b0;
            if ($urandom_range(0, 24) == 0) begin
                registerLoad = 1'b0;
                tick(2 * (WIDTH + 2));
            end
        end

        registerLoad = 1'b0;
        tick(2 * (WIDTH + 2) + 10);
        chk("scoreboard_drained", exp_q.size(), 0);
        chk("conversions_completed", int'(pops >= 5), 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
